// File: rtl/riscv_multi_pkg.sv
// riscv_multi_pkg: shared state, opcode, ALU-op, immediate and mux-select encodings for the multicycle controller
package riscv_multi_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH     = 4'd0;
  localparam state_t S_DECODE    = 4'd1;
  localparam state_t S_MEM_ADR   = 4'd2;
  localparam state_t S_MEM_RD    = 4'd3;
  localparam state_t S_MEM_WB    = 4'd4;
  localparam state_t S_MEM_WR    = 4'd5;
  localparam state_t S_EXEC_R    = 4'd6;
  localparam state_t S_EXEC_I    = 4'd7;
  localparam state_t S_ALU_WB    = 4'd8;
  localparam state_t S_BRANCH    = 4'd9;
  localparam state_t S_JAL       = 4'd10;
  localparam state_t S_JALR      = 4'd11;
  localparam state_t S_LUI       = 4'd12;
  localparam state_t S_ERROR     = 4'd13;
  localparam state_t S_JALR_LINK = 4'd14;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
endpackage

// File: rtl/riscv_alu_dec.sv
// riscv_alu_dec: maps funct3/funct7b5 and R-vs-I class onto an ALU operation code
module riscv_alu_dec
  import riscv_multi_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_r,
  output logic [3:0] alu_ctrl
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      3'b000: alu_ctrl = (op_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_ctrl = ALU_SLL;
      3'b010: alu_ctrl = ALU_SLT;
      3'b011: alu_ctrl = ALU_SLTU;
      3'b100: alu_ctrl = ALU_XOR;
      3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_ctrl = ALU_OR;
      default: alu_ctrl = ALU_AND;
    endcase
  end
endmodule

// File: rtl/riscv_multi_ctrl.sv
// riscv_multi_ctrl: multicycle RV32 control FSM driving write enables, mux selects and ALU op from IR and ALU flags
module riscv_multi_ctrl
  import riscv_multi_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        neg,
  input  logic        ov,
  input  logic        cy,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_we,
  output logic        adr_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  res_src,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_ctrl,
  output logic        err,
  output logic [31:0] pc_rst_val
);
  state_t state, state_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_ctrl;
  logic pc_en, ir_en, reg_en, mem_en, take;
  logic unused;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused = ^{instr[31], instr[29:15], instr[11:7]};
  assign pc_rst_val = RESET_PC;
  assign take = funct3 == 3'b000 ? zero :
                funct3 == 3'b001 ? !zero :
                funct3 == 3'b100 ? (neg ^ ov) :
                funct3 == 3'b101 ? !(neg ^ ov) :
                funct3 == 3'b110 ? !cy :
                funct3 == 3'b111 ? cy : 1'b0;
  riscv_alu_dec u_alu_dec (
    .funct3   (funct3),
    .funct7b5 (instr[30]),
    .op_r     (opcode == OP_R),
    .alu_ctrl (dec_ctrl)
  );
  always_ff @(posedge clk)
    state <= !rst ? S_FETCH : state_n;
  always_comb begin
    state_n = S_ERROR;
    case (state)
      S_FETCH:   state_n = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LOAD, OP_STORE: state_n = S_MEM_ADR;
          OP_R:              state_n = S_EXEC_R;
          OP_I:              state_n = S_EXEC_I;
          OP_BRANCH:         state_n = funct3[2:1] == 2'b01 ? S_ERROR : S_BRANCH;
          OP_JAL:            state_n = S_JAL;
          OP_JALR:           state_n = S_JALR;
          OP_LUI:            state_n = S_LUI;
          default:           state_n = S_ERROR;
        endcase
      S_MEM_ADR: state_n = opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  state_n = S_MEM_WB;
      S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH: state_n = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_LUI, S_JALR_LINK: state_n = S_ALU_WB;
      S_JALR:    state_n = S_JALR_LINK;
      default:   state_n = S_ERROR;
    endcase
  end
  always_comb begin
    {pc_en, ir_en, reg_en, mem_en, adr_src} = '0;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    res_src   = RES_ALUOUT;
    imm_src   = IMM_I;
    alu_ctrl  = ALU_ADD;
    err       = state == S_ERROR;
    case (state)
      S_FETCH: begin
        {ir_en, pc_en} = 2'b11;
        alu_src_b = B_FOUR;
        res_src   = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_src   = opcode == OP_JAL ? IMM_J : IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_src   = opcode == OP_STORE ? IMM_S : IMM_I;
      end
      S_MEM_RD: adr_src = 1'b1;
      S_MEM_WB: begin
        res_src = RES_DATA;
        reg_en  = 1'b1;
      end
      S_MEM_WR: {adr_src, mem_en} = 2'b11;
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = state == S_EXEC_I ? B_IMM : B_RS2;
        alu_ctrl  = dec_ctrl;
      end
      S_ALU_WB: reg_en = 1'b1;
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_ctrl  = ALU_SUB;
        pc_en     = take;
      end
      S_JAL, S_JALR_LINK: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_en     = state == S_JAL;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        res_src   = RES_ALU;
        pc_en     = 1'b1;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        imm_src   = IMM_U;
      end
      default: ;
    endcase
  end
  assign pc_we  = rst & pc_en;
  assign ir_we  = rst & ir_en;
  assign reg_we = rst & reg_en;
  assign mem_we = rst & mem_en;
endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// tb_riscv_multi_ctrl: randomized and directed checks of the multicycle controller against a per-instruction cycle-sequence model
module tb_riscv_multi_ctrl;
  import riscv_multi_pkg::*;
  logic clk = 0, rst = 0, zero = 0, neg = 0, ov = 0, cy = 0;
  logic [31:0] instr = 0;
  logic pc_we, ir_we, reg_we, mem_we, adr_src, err;
  logic [1:0] alu_src_a, alu_src_b, res_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic [31:0] pc_rst_val;
  riscv_multi_ctrl #(.RESET_PC(32'h0000_1000)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .neg(neg), .ov(ov), .cy(cy),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .res_src(res_src), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .err(err), .pc_rst_val(pc_rst_val)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic [18:0] exp_q[$], msk_q[$];
  bit ill;
  wire [18:0] obs = {pc_we, ir_we, reg_we, mem_we, adr_src, alu_src_a, alu_src_b, res_src, imm_src, alu_ctrl, err};
  function automatic logic [18:0] v(logic [3:0] we, logic adr, logic [1:0] a, logic [1:0] b, logic [1:0] r, logic [2:0] im, logic [3:0] alu, logic e);
    return {we, adr, a, b, r, im, alu, e};
  endfunction
  function automatic logic [18:0] m(bit adr, bit a, bit b, bit r, bit im, bit alu);
    return {4'hf, adr, {2{a}}, {2{b}}, {2{r}}, {3{im}}, {4{alu}}, 1'b1};
  endfunction
  function automatic logic [31:0] enc(logic [6:0] op, logic [2:0] f3, logic f7);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = op;
    r[14:12] = f3;
    r[30] = f7;
    return r;
  endfunction
  function automatic logic [3:0] aluop(logic [2:0] f3, logic f7, bit is_r);
    case (f3)
      3'd0: return (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'd1: return ALU_SLL;
      3'd2: return ALU_SLT;
      3'd3: return ALU_SLTU;
      3'd4: return ALU_XOR;
      3'd5: return f7 ? ALU_SRA : ALU_SRL;
      3'd6: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  task automatic push(logic [18:0] e, logic [18:0] k);
    exp_q.push_back(e);
    msk_q.push_back(k);
  endtask
  task automatic build(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, tk;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[30];
    exp_q.delete();
    msk_q.delete();
    ill = 0;
    push(v(4'b0100 | 4'b1000, 0, 2'b00, 2'b10, 2'b10, 0, ALU_ADD, 0), m(1, 1, 1, 1, 0, 1));
    push(v(4'b0000, 0, 2'b01, 2'b01, 2'b00, 3'd2, ALU_ADD, 0), m(0, 1, 1, 0, op == 7'b1100011, 1));
    case (op)
      7'b0000011: begin
        push(v(0, 0, 2'b10, 2'b01, 0, 3'd0, ALU_ADD, 0), m(0, 1, 1, 0, 1, 1));
        push(v(0, 1, 0, 0, 2'b00, 0, 0, 0), m(1, 0, 0, 1, 0, 0));
        push(v(4'b0010, 0, 0, 0, 2'b01, 0, 0, 0), m(0, 0, 0, 1, 0, 0));
      end
      7'b0100011: begin
        push(v(0, 0, 2'b10, 2'b01, 0, 3'd1, ALU_ADD, 0), m(0, 1, 1, 0, 1, 1));
        push(v(4'b0001, 1, 0, 0, 2'b00, 0, 0, 0), m(1, 0, 0, 1, 0, 0));
      end
      7'b0110011, 7'b0010011: begin
        if (op == 7'b0110011) push(v(0, 0, 2'b10, 2'b00, 0, 0, aluop(f3, f7, 1), 0), m(0, 1, 1, 0, 0, 1));
        else push(v(0, 0, 2'b10, 2'b01, 0, 3'd0, aluop(f3, f7, 0), 0), m(0, 1, 1, 0, 1, 1));
        push(v(4'b0010, 0, 0, 0, 2'b00, 0, 0, 0), m(0, 0, 0, 1, 0, 0));
      end
      7'b1100011: begin
        case (f3)
          3'd0: tk = a == b;
          3'd1: tk = a != b;
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          3'd7: tk = a >= b;
          default: begin tk = 0; ill = 1; end
        endcase
        if (!ill) push(v({tk, 3'b000}, 0, 2'b10, 2'b00, 2'b00, 0, ALU_SUB, 0), m(0, 1, 1, 1, 0, 1));
      end
      7'b1101111: begin
        push(v(4'b1000, 0, 2'b01, 2'b10, 2'b00, 0, ALU_ADD, 0), m(0, 1, 1, 1, 0, 1));
        push(v(4'b0010, 0, 0, 0, 2'b00, 0, 0, 0), m(0, 0, 0, 1, 0, 0));
      end
      7'b1100111: begin
        push(v(4'b1000, 0, 2'b10, 2'b01, 2'b10, 3'd0, ALU_ADD, 0), m(0, 1, 1, 1, 1, 1));
        push(v(4'b0000, 0, 2'b01, 2'b10, 2'b00, 0, ALU_ADD, 0), m(0, 1, 1, 1, 0, 1));
        push(v(4'b0010, 0, 0, 0, 2'b00, 0, 0, 0), m(0, 0, 0, 1, 0, 0));
      end
      7'b0110111: begin
        push(v(0, 0, 2'b11, 2'b01, 0, 3'd4, ALU_ADD, 0), m(0, 1, 1, 0, 1, 1));
        push(v(4'b0010, 0, 0, 0, 2'b00, 0, 0, 0), m(0, 0, 0, 1, 0, 0));
      end
      default: ill = 1;
    endcase
    if (ill) repeat (10) push(v(0, 0, 0, 0, 0, 0, 0, 1), m(0, 0, 0, 0, 0, 0));
  endtask
  task automatic set_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    zero = d == 0;
    neg = d[31];
    ov = (a[31] != b[31]) && (d[31] != a[31]);
    cy = a >= b;
  endtask
  task automatic run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input string nm);
    build(ins, a, b);
    instr = ins;
    set_flags(a, b);
    foreach (exp_q[k]) begin
      #1;
      tests++;
      if ((obs & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        fails++;
        $display("FAIL %s step %0d instr=%h: got %b required %b (mask %b)", nm, k, ins, obs, exp_q[k], msk_q[k]);
      end
      @(negedge clk);
    end
    if (ill) begin
      rst = 0;
      #1;
      tests++;
      if ({pc_we, ir_we, reg_we, mem_we} !== 4'b0000) begin
        fails++;
        $display("FAIL %s enables-in-reset: got %b required 0000", nm, {pc_we, ir_we, reg_we, mem_we});
      end
      @(negedge clk);
      rst = 1;
    end
    #1;
    tests++;
    if ({ir_we, err} !== 2'b10) begin
      fails++;
      $display("FAIL %s back-to-fetch: ir_we,err got %b required 10", nm, {ir_we, err});
    end
  endtask
  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if ({pc_we, ir_we, reg_we, mem_we, err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b required 00000", {pc_we, ir_we, reg_we, mem_we, err});
    end
    tests++;
    if (pc_rst_val !== 32'h0000_1000) begin
      fails++;
      $display("FAIL pc_rst_val: got %h required 00001000", pc_rst_val);
    end
    rst = 1;
  endtask
  task automatic test_branch();
    run(enc(OP_BRANCH, 3'b101, 0), 32'd2, 32'h8000_0000, "bge_neg_ov");
    run(enc(OP_BRANCH, 3'b101, 0), 32'd77, 32'd77, "bge_equal");
    run(enc(OP_BRANCH, 3'b100, 0), 32'd20, 32'd10, "blt_not_taken");
    run(enc(OP_BRANCH, 3'b110, 0), 32'd1, 32'hffff_ffff, "bltu_taken");
    run(enc(OP_BRANCH, 3'b010, 0), 32'd1, 32'd2, "branch_f3_010");
  endtask
  task automatic test_load_store();
    run(enc(OP_LOAD, 3'b010, 0), 0, 0, "lw");
    run(enc(OP_STORE, 3'b010, 0), 0, 0, "sw");
    run(enc(OP_JAL, 3'b000, 0), 0, 0, "jal");
    run(enc(OP_JALR, 3'b000, 0), 0, 0, "jalr");
    run(enc(OP_LUI, 3'b000, 0), 0, 0, "lui");
    run(enc(OP_R, 3'b000, 1), 0, 0, "sub");
    run(enc(OP_I, 3'b000, 1), 0, 0, "addi_f7set");
    run(enc(OP_I, 3'b101, 1), 0, 0, "srai");
  endtask
  task automatic test_error();
    run(enc(7'h7f, 0, 0), 0, 0, "illegal_7f");
  endtask
  task automatic test_reset_mid();
    build(enc(OP_LOAD, 3'b010, 0), 0, 0);
    instr = enc(OP_LOAD, 3'b010, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ((obs & msk_q[k]) !== (exp_q[k] & msk_q[k])) begin
        fails++;
        $display("FAIL mid_reset step %0d: got %b required %b", k, obs, exp_q[k]);
      end
      @(negedge clk);
    end
    rst = 0;
    #1;
    tests++;
    if ({pc_we, ir_we, reg_we, mem_we} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_reset enables: got %b required 0000", {pc_we, ir_we, reg_we, mem_we});
    end
    @(negedge clk);
    rst = 1;
    #1;
    tests++;
    if ({ir_we, reg_we, err} !== 3'b100) begin
      fails++;
      $display("FAIL mid_reset fetch: ir_we,reg_we,err got %b required 100", {ir_we, reg_we, err});
    end
  endtask
  task automatic test_random();
    logic [6:0] ops [8];
    logic [6:0] op;
    logic [31:0] a, b;
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9) < 8 ? ops[$urandom_range(0, 7)] : 7'($urandom);
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
      run(enc(op, 3'($urandom), 1'($urandom)), a, b, "random");
    end
  endtask
  initial begin
    test_reset();
    test_branch();
    test_load_store();
    test_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
